// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D-cache memory port arbiter: FSM state, client id,
// default bus widths and the tie-break rule.
package mem_port_arbiter_pkg;

  localparam int S_ADDR = 32;
  localparam int S_LINE = 256;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } arb_client_t;

  // Winner of a simultaneous I/D request: D under fixed priority, otherwise
  // whichever client was not granted last.
  function automatic arb_client_t tie_winner(input logic fixed_pri,
                                             input arb_client_t last_grant);
    return (fixed_pri || (last_grant == CLIENT_I)) ? CLIENT_D : CLIENT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache-client ports and the downstream line port seen by
// the memory port arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int s_addr = S_ADDR,
  parameter int s_line = S_LINE
);

  // Handshake: a request is a level. The client raises read (or write) with
  // addr/wdata and holds all of them stable until its one-cycle resp; resp
  // completes the transaction and rdata is valid only in that cycle. The
  // adaptor side follows the same rule with mem_read/mem_write and mem_resp.
  logic [s_addr-1:0] i_addr;
  logic              i_read;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;

  logic [s_addr-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;

  logic [s_addr-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [s_line-1:0] mem_wdata;
  logic [s_line-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache: grants one
// client per line transaction, steers its request downstream, returns rdata/resp.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int s_addr    = S_ADDR,
  parameter int s_line    = S_LINE,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output arb_state_t          o_state,
  output arb_client_t         o_last_grant
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;

  logic [1:0]  r_state;
  arb_client_t r_last_grant;

  logic [1:0]  w_next_state;
  logic        w_txn_done;
  arb_client_t w_done_client;
  logic        w_i_req;
  logic        w_d_req;

  logic [s_addr-1:0] w_mem_addr;
  logic [s_line-1:0] w_mem_wdata;
  logic [s_line-1:0] w_i_rdata;
  logic [s_line-1:0] w_d_rdata;

  assign w_i_req = bus.i_read;
  assign w_d_req = bus.d_read | bus.d_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= CLIENT_I;
    end else begin
      r_state <= w_next_state;
      if (w_txn_done) begin
        r_last_grant <= w_done_client;
      end
    end
  end

  // The owner is released on its mem_resp, or early if it withdraws its request.
  always_comb begin
    w_next_state  = r_state;
    w_txn_done    = 1'b0;
    w_done_client = CLIENT_I;
    case (r_state)
      ST_IDLE: begin
        if (w_i_req && w_d_req) begin
          w_next_state = (tie_winner(FIXED_PRI, r_last_grant) == CLIENT_D) ?
                         ST_SERVE_D : ST_SERVE_I;
        end else if (w_i_req) begin
          w_next_state = ST_SERVE_I;
        end else if (w_d_req) begin
          w_next_state = ST_SERVE_D;
        end
      end
      ST_SERVE_I: begin
        if (bus.mem_resp) begin
          w_next_state  = ST_IDLE;
          w_txn_done    = 1'b1;
          w_done_client = CLIENT_I;
        end else if (!w_i_req) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SERVE_D: begin
        if (bus.mem_resp) begin
          w_next_state  = ST_IDLE;
          w_txn_done    = 1'b1;
          w_done_client = CLIENT_D;
        end else if (!w_d_req) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Downstream controls depend only on state and the owner's inputs, so
  // mem_resp never reaches mem_read/mem_write combinationally.
  always_comb begin
    w_mem_addr    = '0;
    w_mem_wdata   = '0;
    w_i_rdata     = '0;
    w_d_rdata     = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    case (r_state)
      ST_SERVE_I: begin
        w_mem_addr   = bus.i_addr;
        bus.mem_read = bus.i_read;
        bus.i_resp   = bus.mem_resp;
        if (bus.mem_resp) begin
          w_i_rdata = bus.mem_rdata;
        end
      end
      ST_SERVE_D: begin
        w_mem_addr    = bus.d_addr;
        w_mem_wdata   = bus.d_wdata;
        bus.mem_read  = bus.d_read;
        bus.mem_write = bus.d_write;
        bus.d_resp    = bus.mem_resp;
        if (bus.mem_resp) begin
          w_d_rdata = bus.mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.i_rdata   = w_i_rdata;
  assign bus.d_rdata   = w_d_rdata;

  assign o_state      = arb_state_t'(r_state);
  assign o_last_grant = r_last_grant;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write));

  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_SERVE_I) |-> (bus.i_read || bus.mem_resp));

  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_SERVE_D) |-> (bus.d_read || bus.d_write || bus.mem_resp));

endmodule
